// File: rtl/ddr2_write_arbiter_pkg.sv
// Shared types and widths for the DDR2 write arbiter slice.
// Holds the arbiter state encoding and the DDR2 FIFO widths.
package ddr2_pkg;

   localparam int DDR2_ADDR_W    = 31;
   localparam int DDR2_DATA_W    = 128;
   localparam int DDR2_MASK_W    = 16;
   localparam int BURSTS_PER_TXN = 2;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BEAT2 = 1'b1
   } arb_state_t;

endpackage

// File: rtl/ddr2_write_arbiter_if.sv
// One DDR2 write channel: af address + wdf data/mask, each with a full flag.
// master = writer (drives strobes/data), slave = consumer (drives full flags).
interface ddr2_wr_if
   import ddr2_pkg::*;
#(
   parameter int ADDR_W = DDR2_ADDR_W,
   parameter int DATA_W = DDR2_DATA_W,
   parameter int MASK_W = DDR2_MASK_W
) ();

   logic [ADDR_W-1:0] af_addr_din;
   logic              af_wr_en;
   logic [DATA_W-1:0] wdf_din;
   logic              wdf_wr_en;
   logic [MASK_W-1:0] wdf_mask_din;
   logic              af_full;
   logic              wdf_full;

   modport master (
      output af_addr_din, af_wr_en,
      output wdf_din, wdf_wr_en, wdf_mask_din,
      input  af_full, wdf_full
   );

   modport slave (
      input  af_addr_din, af_wr_en,
      input  wdf_din, wdf_wr_en, wdf_mask_din,
      output af_full, wdf_full
   );

endinterface

// File: rtl/ddr2_write_arbiter_mux.sv
// ddr2_wr_port_mux: combinational select of addr/data/mask/enables by sel.
// Ports: sel, per-port request fields (suffix 0/1), selected fields out.
module ddr2_wr_port_mux #(
   parameter int ADDR_W = 31,
   parameter int DATA_W = 128,
   parameter int MASK_W = 16
) (
   input  logic              sel,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              af_en0,
   input  logic              af_en1,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   input  logic              wdf_en0,
   input  logic              wdf_en1,
   input  logic [MASK_W-1:0] mask0,
   input  logic [MASK_W-1:0] mask1,
   output logic [ADDR_W-1:0] addr,
   output logic              af_en,
   output logic [DATA_W-1:0] data,
   output logic              wdf_en,
   output logic [MASK_W-1:0] mask
);

   assign addr   = sel ? addr1   : addr0;
   assign af_en  = sel ? af_en1  : af_en0;
   assign data   = sel ? data1   : data0;
   assign wdf_en = sel ? wdf_en1 : wdf_en0;
   assign mask   = sel ? mask1   : mask0;

endmodule

// File: rtl/ddr2_write_arbiter.sv
// Two-port atomic DDR2 write arbiter (1 af entry + 2 wdf bursts per txn).
// Ports: clk, rst_n, p0/p1 (writer channels), ddr (to DDR2 FIFOs), owner.
// Optional ARB_STATS_EN adds txn_cnt0, txn_cnt1, stall_cnt1 counters.
module ddr2_write_arbiter
   import ddr2_pkg::*;
#(
   parameter int ADDR_W = DDR2_ADDR_W,
   parameter int DATA_W = DDR2_DATA_W,
   parameter int MASK_W = DDR2_MASK_W
) (
   input  logic        clk,
   input  logic        rst_n,
   ddr2_wr_if.slave    p0,
   ddr2_wr_if.slave    p1,
   ddr2_wr_if.master   ddr,
   output logic        owner
`ifdef ARB_STATS_EN
   ,
   output logic [31:0] txn_cnt0,
   output logic [31:0] txn_cnt1,
   output logic [31:0] stall_cnt1
`endif
);

   arb_state_t state;
   logic gnt;
   logic rr;
   logic sel;
   logic full_any;
   logic af_we;
   logic wdf_we;

   logic [ADDR_W-1:0] m_addr;
   logic              m_af_en;
   logic [DATA_W-1:0] m_data;
   logic              m_wdf_en;
   logic [MASK_W-1:0] m_mask;

   // Owner of the current beat; locked to gnt while mid-transaction.
   always_comb begin
      sel = gnt;
      if (state == ARB_IDLE) begin
         unique case (1'b1)
            (p0.af_wr_en & ~p1.af_wr_en): sel = 1'b0;
            (p1.af_wr_en & ~p0.af_wr_en): sel = 1'b1;
            (p0.af_wr_en &  p1.af_wr_en): sel = rr;
            default:                      sel = gnt;
         endcase
      end
   end

   ddr2_wr_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .MASK_W (MASK_W)
   ) u_mux (
      .sel     (sel),
      .addr0   (p0.af_addr_din),
      .addr1   (p1.af_addr_din),
      .af_en0  (p0.af_wr_en),
      .af_en1  (p1.af_wr_en),
      .data0   (p0.wdf_din),
      .data1   (p1.wdf_din),
      .wdf_en0 (p0.wdf_wr_en),
      .wdf_en1 (p1.wdf_wr_en),
      .mask0   (p0.wdf_mask_din),
      .mask1   (p1.wdf_mask_din),
      .addr    (m_addr),
      .af_en   (m_af_en),
      .data    (m_data),
      .wdf_en  (m_wdf_en),
      .mask    (m_mask)
   );

   // Owner must see room in both FIFOs; loser always sees full.
   assign full_any = ddr.af_full | ddr.wdf_full;

   assign p0.af_full  =  sel | full_any;
   assign p0.wdf_full =  sel | full_any;
   assign p1.af_full  = ~sel | full_any;
   assign p1.wdf_full = ~sel | full_any;

   // Beat 1 needs addr and data together; beat 2 is data only.
   assign af_we  = (state == ARB_IDLE) & m_af_en & m_wdf_en & ~full_any;
   assign wdf_we = (state == ARB_IDLE) ? af_we : (m_wdf_en & ~full_any);

   assign ddr.af_addr_din  = m_addr;
   assign ddr.af_wr_en     = af_we;
   assign ddr.wdf_din      = m_data;
   assign ddr.wdf_wr_en    = wdf_we;
   assign ddr.wdf_mask_din = m_mask;
   assign owner            = sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ARB_IDLE;
         gnt   <= 1'b0;
         rr    <= 1'b0;
      end else begin
         unique case (state)
            ARB_IDLE: begin
               if (af_we) begin
                  gnt   <= sel;
                  state <= ARB_BEAT2;
               end
            end
            ARB_BEAT2: begin
               if (wdf_we) begin
                  state <= ARB_IDLE;
                  rr    <= ~gnt;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

`ifdef ARB_STATS_EN
   logic txn_done;

   assign txn_done = (state == ARB_BEAT2) & wdf_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txn_cnt0   <= '0;
         txn_cnt1   <= '0;
         stall_cnt1 <= '0;
      end else begin
         if (txn_done & ~gnt)
            txn_cnt0 <= txn_cnt0 + 32'd1;
         if (txn_done & gnt)
            txn_cnt1 <= txn_cnt1 + 32'd1;
         if (p1.af_wr_en & ~sel)
            stall_cnt1 <= stall_cnt1 + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ddr2_write_arbiter.sv
// Testbench for ddr2_write_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_ddr2_write_arbiter;
   import ddr2_pkg::*;

   localparam logic [127:0] DA5 = {16{8'hA5}};
   localparam logic [127:0] D5A = {16{8'h5A}};
   localparam logic [127:0] DC3 = {16{8'hC3}};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic owner;
   always #5 clk = ~clk;

   ddr2_wr_if p0_if ();
   ddr2_wr_if p1_if ();
   ddr2_wr_if ddr_if ();

`ifdef ARB_STATS_EN
   logic [31:0] txn_cnt0, txn_cnt1, stall_cnt1;
`endif

   ddr2_write_arbiter #(
      .ADDR_W (DDR2_ADDR_W),
      .DATA_W (DDR2_DATA_W),
      .MASK_W (DDR2_MASK_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .p0         (p0_if),
      .p1         (p1_if),
      .ddr        (ddr_if),
      .owner      (owner)
`ifdef ARB_STATS_EN
      ,
      .txn_cnt0   (txn_cnt0),
      .txn_cnt1   (txn_cnt1),
      .stall_cnt1 (stall_cnt1)
`endif
   );

   int tests = 0;
   int fails = 0;

   // Copies of what each writer is presenting, read by the model.
   bit            q_aen [2];
   bit            q_wen [2];
   logic [30:0]   q_addr[2];
   logic [127:0]  q_data[2];
   logic [15:0]   q_mask[2];

   task automatic set_p(input bit p, input bit aen, input bit wen,
                        input logic [30:0] a, input logic [127:0] d,
                        input logic [15:0] m);
      q_aen[p] = aen; q_wen[p] = wen;
      q_addr[p] = a; q_data[p] = d; q_mask[p] = m;
      if (p == 1'b0) begin
         p0_if.af_wr_en = aen; p0_if.wdf_wr_en = wen;
         p0_if.af_addr_din = a; p0_if.wdf_din = d;
         p0_if.wdf_mask_din = m;
      end else begin
         p1_if.af_wr_en = aen; p1_if.wdf_wr_en = wen;
         p1_if.af_addr_din = a; p1_if.wdf_din = d;
         p1_if.wdf_mask_din = m;
      end
   endtask

   task automatic clr_inputs();
      set_p(1'b0, 1'b0, 1'b0, '0, '0, '0);
      set_p(1'b1, 1'b0, 1'b0, '0, '0, '0);
      ddr_if.af_full = 1'b0;
      ddr_if.wdf_full = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clr_inputs();
      rst_n = 1'b0;
      @(negedge clk); #1;
      tests++;
      if ({ddr_if.af_wr_en, ddr_if.wdf_wr_en} !== 2'b00) begin
         fails++;
         $display("FAIL reset_en: got %b want 00",
                  {ddr_if.af_wr_en, ddr_if.wdf_wr_en});
      end
      tests++;
      if (owner !== 1'b0) begin
         fails++; $display("FAIL reset_owner: got %b want 0", owner);
      end
      rst_n = 1'b1;
      @(negedge clk); #1;
      tests++;
      if ({p0_if.af_full, p0_if.wdf_full, p1_if.af_full, p1_if.wdf_full,
           ddr_if.af_wr_en, ddr_if.wdf_wr_en} !== 6'b001100) begin
         fails++;
         $display("FAIL idle_flags: got %b want 001100",
                  {p0_if.af_full, p0_if.wdf_full, p1_if.af_full,
                   p1_if.wdf_full, ddr_if.af_wr_en, ddr_if.wdf_wr_en});
      end
      ddr_if.af_full = 1'b1; #1;
      tests++;
      if ({p0_if.af_full, p0_if.wdf_full} !== 2'b11) begin
         fails++;
         $display("FAIL idle_p0_full: got %b want 11",
                  {p0_if.af_full, p0_if.wdf_full});
      end
      ddr_if.af_full = 1'b0;
   endtask

   task automatic test_single_p0();
      do_reset();
      @(negedge clk);
      set_p(1'b0, 1'b1, 1'b1, 31'h1200, DA5, 16'h00F0); #1;
      tests++;
      if ({ddr_if.af_wr_en, ddr_if.wdf_wr_en} !== 2'b11 ||
          ddr_if.af_addr_din !== 31'h1200 || ddr_if.wdf_din !== DA5 ||
          ddr_if.wdf_mask_din !== 16'h00F0) begin
         fails++;
         $display("FAIL single_beat1: en=%b addr=%h mask=%h want 11 1200 00f0",
                  {ddr_if.af_wr_en, ddr_if.wdf_wr_en},
                  ddr_if.af_addr_din, ddr_if.wdf_mask_din);
      end
      @(negedge clk);
      set_p(1'b0, 1'b0, 1'b1, 31'h1200, D5A, 16'h0F00); #1;
      tests++;
      if ({ddr_if.af_wr_en, ddr_if.wdf_wr_en} !== 2'b01 ||
          ddr_if.wdf_din !== D5A || ddr_if.wdf_mask_din !== 16'h0F00) begin
         fails++;
         $display("FAIL single_beat2: en=%b mask=%h want 01 0f00",
                  {ddr_if.af_wr_en, ddr_if.wdf_wr_en}, ddr_if.wdf_mask_din);
      end
      @(negedge clk); #1;
      tests++;
      if (ddr_if.wdf_wr_en !== 1'b0) begin
         fails++;
         $display("FAIL single_idle_lone_wdf: got %b want 0",
                  ddr_if.wdf_wr_en);
      end
      @(negedge clk);
      set_p(1'b0, 1'b1, 1'b1, 31'h1240, DA5, 16'h0); #1;
      tests++;
      if (ddr_if.af_wr_en !== 1'b1) begin
         fails++;
         $display("FAIL single_next_beat1: got %b want 1", ddr_if.af_wr_en);
      end
      @(negedge clk);
      set_p(1'b0, 1'b0, 1'b1, 31'h1240, D5A, 16'h0);
      @(negedge clk);
      clr_inputs();
   endtask

   task automatic test_contention();
      do_reset();
      @(negedge clk);
      set_p(1'b0, 1'b1, 1'b1, 31'h1000, DA5, 16'h0);
      set_p(1'b1, 1'b1, 1'b1, 31'h4000, DC3, 16'hFFFF); #1;
      tests++;
      if (owner !== 1'b0 || ddr_if.af_addr_din !== 31'h1000 ||
          ddr_if.af_wr_en !== 1'b1 ||
          {p0_if.af_full, p1_if.af_full, p1_if.wdf_full} !== 3'b011) begin
         fails++;
         $display("FAIL contend_beat1: owner=%b addr=%h af=%b want 0 1000 1",
                  owner, ddr_if.af_addr_din, ddr_if.af_wr_en);
      end
      @(negedge clk);
      set_p(1'b0, 1'b0, 1'b1, 31'h1000, D5A, 16'h0); #1;
      tests++;
      if ({ddr_if.af_wr_en, ddr_if.wdf_wr_en} !== 2'b01 ||
          {p1_if.af_full, p1_if.wdf_full} !== 2'b11) begin
         fails++;
         $display("FAIL contend_beat2: en=%b p1full=%b want 01 11",
                  {ddr_if.af_wr_en, ddr_if.wdf_wr_en},
                  {p1_if.af_full, p1_if.wdf_full});
      end
      @(negedge clk);
      set_p(1'b0, 1'b1, 1'b1, 31'h1080, DA5, 16'h0); #1;
      tests++;
      if (owner !== 1'b1 || ddr_if.af_addr_din !== 31'h4000 ||
          ddr_if.af_wr_en !== 1'b1 || ddr_if.wdf_din !== DC3 ||
          p0_if.af_full !== 1'b1) begin
         fails++;
         $display("FAIL contend_p1_grant: owner=%b addr=%h af=%b want 1 4000 1",
                  owner, ddr_if.af_addr_din, ddr_if.af_wr_en);
      end
      @(negedge clk);
      set_p(1'b0, 1'b0, 1'b0, '0, '0, '0);
      set_p(1'b1, 1'b0, 1'b1, 31'h4000, DC3, 16'h0); #1;
      tests++;
      if (ddr_if.wdf_wr_en !== 1'b1 || owner !== 1'b1) begin
         fails++;
         $display("FAIL contend_p1_beat2: wdf=%b owner=%b want 1 1",
                  ddr_if.wdf_wr_en, owner);
      end
      @(negedge clk);
      clr_inputs();
   endtask

   task automatic test_backpressure();
      do_reset();
      @(negedge clk);
      set_p(1'b0, 1'b1, 1'b1, 31'h2000, DA5, 16'h0); #1;
      tests++;
      if (ddr_if.af_wr_en !== 1'b1) begin
         fails++; $display("FAIL bp_beat1: got %b want 1", ddr_if.af_wr_en);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) begin
            set_p(1'b0, 1'b0, 1'b1, 31'h2000, D5A, 16'h0);
            set_p(1'b1, 1'b1, 1'b1, 31'h4000, DC3, 16'h0);
            ddr_if.wdf_full = 1'b1;
         end
         #1;
         tests++;
         if ({ddr_if.af_wr_en, ddr_if.wdf_wr_en, owner,
              p1_if.af_full} !== 4'b0001) begin
            fails++;
            $display("FAIL bp_hold%0d: af/wdf/owner/p1full=%b want 0001", i,
                     {ddr_if.af_wr_en, ddr_if.wdf_wr_en, owner,
                      p1_if.af_full});
         end
      end
      @(negedge clk);
      ddr_if.wdf_full = 1'b0; #1;
      tests++;
      if (ddr_if.wdf_wr_en !== 1'b1 || owner !== 1'b0 ||
          ddr_if.wdf_din !== D5A) begin
         fails++;
         $display("FAIL bp_release: wdf=%b owner=%b want 1 0",
                  ddr_if.wdf_wr_en, owner);
      end
      @(negedge clk);
      set_p(1'b0, 1'b0, 1'b0, '0, '0, '0); #1;
      tests++;
      if (owner !== 1'b1 || ddr_if.af_wr_en !== 1'b1 ||
          ddr_if.af_addr_din !== 31'h4000) begin
         fails++;
         $display("FAIL bp_p1_after: owner=%b af=%b addr=%h want 1 1 4000",
                  owner, ddr_if.af_wr_en, ddr_if.af_addr_din);
      end
      @(negedge clk);
      set_p(1'b1, 1'b0, 1'b1, 31'h4000, DC3, 16'h0);
      @(negedge clk);
      clr_inputs();
   endtask

   task automatic test_protocol_guard();
      do_reset();
      @(negedge clk);
      set_p(1'b0, 1'b0, 1'b1, 31'h3000, DA5, 16'h0); #1;
      tests++;
      if ({ddr_if.af_wr_en, ddr_if.wdf_wr_en} !== 2'b00) begin
         fails++;
         $display("FAIL guard_lone_wdf: got %b want 00",
                  {ddr_if.af_wr_en, ddr_if.wdf_wr_en});
      end
      @(negedge clk);
      set_p(1'b0, 1'b1, 1'b1, 31'h3000, DA5, 16'h0);
      @(negedge clk);
      set_p(1'b0, 1'b1, 1'b1, 31'h3040, D5A, 16'h0); #1;
      tests++;
      if ({ddr_if.af_wr_en, ddr_if.wdf_wr_en} !== 2'b01) begin
         fails++;
         $display("FAIL guard_af_in_beat2: got %b want 01",
                  {ddr_if.af_wr_en, ddr_if.wdf_wr_en});
      end
      @(negedge clk);
      clr_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk);
      set_p(1'b0, 1'b1, 1'b1, 31'h1000, DA5, 16'h0);
      @(negedge clk);
      set_p(1'b0, 1'b0, 1'b1, 31'h1000, D5A, 16'h0);
      @(negedge clk);
      set_p(1'b0, 1'b0, 1'b0, '0, '0, '0);
      set_p(1'b1, 1'b1, 1'b1, 31'h4000, DC3, 16'h0); #1;
      tests++;
      if (owner !== 1'b1 || ddr_if.af_wr_en !== 1'b1) begin
         fails++;
         $display("FAIL rmid_p1_start: owner=%b af=%b want 1 1",
                  owner, ddr_if.af_wr_en);
      end
      @(negedge clk);
      clr_inputs();
      rst_n = 1'b0; #2;
      rst_n = 1'b1; #1;
      tests++;
      if (owner !== 1'b0) begin
         fails++; $display("FAIL rmid_owner: got %b want 0", owner);
      end
      @(negedge clk);
      set_p(1'b0, 1'b1, 1'b1, 31'h1100, DA5, 16'h0);
      set_p(1'b1, 1'b1, 1'b1, 31'h4100, DC3, 16'h0); #1;
      tests++;
      if (owner !== 1'b0 || ddr_if.af_wr_en !== 1'b1 ||
          ddr_if.af_addr_din !== 31'h1100) begin
         fails++;
         $display("FAIL rmid_fresh: owner=%b af=%b addr=%h want 0 1 1100",
                  owner, ddr_if.af_wr_en, ddr_if.af_addr_din);
      end
      @(negedge clk);
      set_p(1'b0, 1'b0, 1'b1, 31'h1100, D5A, 16'h0);
      set_p(1'b1, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      clr_inputs();
   endtask

`ifdef ARB_STATS_EN
   task automatic test_stats();
      bit seq [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         set_p(seq[i], 1'b1, 1'b1, 31'h5000, DA5, 16'h0);
         @(negedge clk);
         set_p(seq[i], 1'b0, 1'b1, 31'h5000, D5A, 16'h0);
         @(negedge clk);
         clr_inputs();
      end
      #1;
      tests++;
      if (txn_cnt0 !== 32'd3 || txn_cnt1 !== 32'd2 ||
          stall_cnt1 !== 32'd0) begin
         fails++;
         $display("FAIL stats_count: c0=%0d c1=%0d st=%0d want 3 2 0",
                  txn_cnt0, txn_cnt1, stall_cnt1);
      end
   endtask
`endif

   task automatic test_random();
      bit          busy, own, pref, s, room, e_af, e_wdf;
      logic [31:0] c0, c1, st;
      busy = 0; own = 0; pref = 0;
      c0 = 0; c1 = 0; st = 0;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++)
            set_p(p[0], $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, 31'($urandom),
                  {$urandom, $urandom, $urandom, $urandom},
                  16'($urandom));
         ddr_if.af_full  = $urandom_range(0, 6) == 0;
         ddr_if.wdf_full = $urandom_range(0, 6) == 0;
         #1;
         // Who owns this cycle, from the arbitration rules.
         if (busy) s = own;
         else if (q_aen[0] && !q_aen[1]) s = 1'b0;
         else if (q_aen[1] && !q_aen[0]) s = 1'b1;
         else if (q_aen[0] && q_aen[1]) s = pref;
         else s = own;
         room  = !ddr_if.af_full && !ddr_if.wdf_full;
         e_af  = !busy && q_aen[s] && q_wen[s] && room;
         e_wdf = busy ? (q_wen[s] && room) : e_af;
         tests++;
         if ({ddr_if.af_wr_en, ddr_if.wdf_wr_en, owner} !==
             {e_af, e_wdf, s}) begin
            fails++;
            $display("FAIL rand_en[%0d]: af/wdf/owner=%b want %b", n,
                     {ddr_if.af_wr_en, ddr_if.wdf_wr_en, owner},
                     {e_af, e_wdf, s});
         end
         tests++;
         if (ddr_if.af_addr_din !== q_addr[s] ||
             ddr_if.wdf_din !== q_data[s] ||
             ddr_if.wdf_mask_din !== q_mask[s]) begin
            fails++;
            $display("FAIL rand_data[%0d]: addr=%h mask=%h want %h %h", n,
                     ddr_if.af_addr_din, ddr_if.wdf_mask_din,
                     q_addr[s], q_mask[s]);
         end
         tests++;
         if ({p0_if.af_full, p0_if.wdf_full, p1_if.af_full,
              p1_if.wdf_full} !==
             {{2{s | !room}}, {2{!s | !room}}}) begin
            fails++;
            $display("FAIL rand_full[%0d]: got %b want %b", n,
                     {p0_if.af_full, p0_if.wdf_full, p1_if.af_full,
                      p1_if.wdf_full}, {{2{s | !room}}, {2{!s | !room}}});
         end
         if (q_aen[1] && !s) st++;
         if (!busy && e_af) begin
            busy = 1; own = s;
         end else if (busy && e_wdf) begin
            busy = 0; pref = !own;
            if (own) c1++; else c0++;
         end
      end
      @(negedge clk);
      clr_inputs();
`ifdef ARB_STATS_EN
      #1;
      tests++;
      if (txn_cnt0 !== c0 || txn_cnt1 !== c1 || stall_cnt1 !== st) begin
         fails++;
         $display("FAIL rand_stats: %0d %0d %0d want %0d %0d %0d",
                  txn_cnt0, txn_cnt1, stall_cnt1, c0, c1, st);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_p0();
      test_contention();
      test_backpressure();
      test_protocol_guard();
      test_reset_mid();
`ifdef ARB_STATS_EN
      test_stats();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ddr2_write_arbiter.md
Name: ddr2_write_arbiter

Overview:
- Two-port write arbiter directly downstream of the frame filler. It merges the filler's DDR2 write stream with a second writer (line engine) onto the single DDR2 address FIFO (af) and write-data FIFO (wdf).
- Each DDR2 write transaction is one af entry plus two 128-bit wdf bursts. The transaction is granted atomically: once started, no other port can interleave.
- Zero-latency combinational datapath; only grant and state are registered.

Parameters:
- ADDR_W, 31, af address width
- DATA_W, 128, wdf data width
- MASK_W, 16, wdf byte-mask width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- p0_af_addr_din  in  ADDR_W  port 0 (frame filler) address
- p0_af_wr_en  in  1  port 0 address write request
- p0_wdf_din  in  DATA_W  port 0 write data
- p0_wdf_wr_en  in  1  port 0 data write request
- p0_wdf_mask_din  in  MASK_W  port 0 byte mask
- p0_af_full  out  1  full flag returned to port 0
- p0_wdf_full  out  1  full flag returned to port 0
- p1_*  (same seven signals)  port 1 (line engine)
- af_full  in  1  DDR2 address FIFO full
- wdf_full  in  1  DDR2 data FIFO full
- af_addr_din  out  ADDR_W  to DDR2
- af_wr_en  out  1  to DDR2
- wdf_din  out  DATA_W  to DDR2
- wdf_wr_en  out  1  to DDR2
- wdf_mask_din  out  MASK_W  to DDR2
- owner  out  1  current/next grant, for debug

Behaviour:
- Registers: state {IDLE, BEAT2}, gnt (1 bit), rr (1 bit, preferred port). Async reset (rst_n=0) → state=IDLE, gnt=0, rr=0. Reset mid-transaction abandons the transaction; no recovery burst is issued.
- Request: req_i = pi_af_wr_en.
- IDLE selection:
  - sel = the single requester if only one requests.
  - sel = rr if both request.
  - sel = gnt if none request.
- BEAT2: sel = gnt.
- Full flags: port sel sees pi_af_full = pi_wdf_full = (af_full | wdf_full), so it writes only when both FIFOs have room. The non-selected port sees both flags = 1.
- Datapath: af_addr_din, wdf_din, wdf_mask_din = mux(sel). Outputs are defined at all times, including when idle.
- IDLE:
  - af_wr_en = wdf_wr_en = psel_af_wr_en & psel_wdf_wr_en & !af_full & !wdf_full.
  - On acceptance (af_wr_en=1): gnt <= sel, state <= BEAT2.
  - A lone wdf_wr_en without af_wr_en is blocked (outputs 0).
- BEAT2:
  - af_wr_en = 0, even if the owner asserts it.
  - wdf_wr_en = pgnt_wdf_wr_en & !af_full & !wdf_full.
  - On acceptance: state <= IDLE, rr <= ~gnt (round-robin fairness).
  - Otherwise hold in BEAT2 indefinitely.
- Latency: 0 cycles, request to DDR2 strobe, same cycle.
- Back-to-back: the same port may start a new transaction in the cycle after its BEAT2 only if the other port is not requesting.
- Simultaneous requests in IDLE: rr wins; loser stalls (sees full) and is guaranteed the next grant.
- Masks pass through unmodified; the arbiter never alters data.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds outputs txn_cnt0, txn_cnt1 (32 bits each) and stall_cnt1 (32 bits).
  - txn_cnt0/txn_cnt1 increment on each completed BEAT2 of port 0/port 1.
  - stall_cnt1 increments each cycle port 1 requests but is not selected.
  - All reset to 0 on rst_n and wrap at 2^32.
- When not defined, these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package ddr2_pkg:
  - state encoding ARB_IDLE=1'b0, ARB_BEAT2=1'b1
  - DDR2_ADDR_W=31, DDR2_DATA_W=128, DDR2_MASK_W=16
  - BURSTS_PER_TXN=2
- One sub-module is natural: ddr2_wr_port_mux (pure combinational select of address/data/mask/enables by sel), instantiated once. The FSM and rr logic stay in the top.

Test Plan:
- Reset then idle: rst_n low → all enables 0, owner=0; release, no requests → enables stay 0, both ports see full only via af_full/wdf_full for sel=0 and 1 for port 1.
- Single port 0 fill: p0 beat1 addr 0x0000_1200, data 0xA5.. with full=0 → af_wr_en=wdf_wr_en=1 same cycle; next p0 wdf beat → wdf_wr_en=1, af_wr_en=0; state back to IDLE.
- Contention: both request at once after reset (rr=0) → port 0 granted, p1 sees full=1 for 2 beats; next cycle port 1 granted with its address 0x0000_4000.
- Backpressure in BEAT2: wdf_full=1 for 5 cycles after beat1 → wdf_wr_en=0, state held, p1 request blocked; on release → beat2 completes.
- Protocol guard: owner asserts af_wr_en during BEAT2 → af_wr_en out stays 0; lone wdf_wr_en in IDLE → blocked.
- Reset mid-transaction: rst_n pulse in BEAT2 → state=IDLE, rr=0; next request treated as a fresh beat1. With ARB_STATS_EN: 3 p0 + 2 p1 transactions → txn_cnt0=3, txn_cnt1=2.
